// File: rtl/memory_driver_pkg.sv
// Shared AXI encodings and driver state enum for the memory driver.
// No logic; constants and a size helper only.
// Imported by the interface consumer and the driver top.
package memory_driver_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         FSM_STATE_W    = 3;

    typedef enum logic [FSM_STATE_W-1:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RD_CPL
    } drv_state_t;

    // AXI AxSIZE encoding for a full-width beat of strb_width bytes
    function automatic logic [2:0] axi_size(input int strb_width);
        return 3'($clog2(strb_width));
    endfunction

endpackage

// File: rtl/memory_driver_if.sv
// AXI4 bus bundle between the memory driver (master) and a RAM slave.
// Pure wiring, no latency.
// Backpressure carried by the per-channel valid/ready pairs.
interface memory_driver_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) ();
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rid, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rid, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/memory_driver.sv
// Converts single-word engine read/write requests into single-beat AXI4 transfers.
// Latency: accept to read data valid 3 cycles, accept to ready again after write 3 cycles (zero-wait slave).
// Backpressure: mem_ready only in IDLE (one outstanding); read data held until mem_rd_ready; AXI stalls hold state.
module memory_driver
    import memory_driver_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int RAM_ID_WIDTH   = 8,
    parameter int AXI_ID         = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_rd,
    input  logic                      mem_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
    output logic                      mem_rd_valid,
    input  logic                      mem_rd_ready,
    output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
    output logic                      mem_error,

    memory_driver_if.master           m_axi
);

    drv_state_t                state;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [RAM_DATA_WIDTH-1:0] wdata_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      aw_pend_nxt;
    logic                      w_pend_nxt;
    logic                      unused_ok;

    // AW and W retire independently; each stays pending until its own handshake
    always_comb begin
        aw_pend_nxt = awvalid_q && !m_axi.awready;
        w_pend_nxt  = wvalid_q  && !m_axi.wready;
    end

    // Driver FSM with all handshake outputs registered
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            mem_ready    <= 1'b1;
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= '0;
            mem_error    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (mem_wr) begin
                            // write wins a rd+wr collision, which is flagged
                            addr_q    <= mem_addr;
                            wdata_q   <= mem_wr_data;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            mem_ready <= 1'b0;
                            state     <= WR_REQ;
                            if (mem_rd) begin
                                mem_error <= 1'b1;
                            end
                        end else if (mem_rd) begin
                            addr_q    <= mem_addr;
                            arvalid_q <= 1'b1;
                            mem_ready <= 1'b0;
                            state     <= RD_REQ;
                        end else begin
                            // request with no direction is swallowed
                            mem_error <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    awvalid_q <= aw_pend_nxt;
                    wvalid_q  <= w_pend_nxt;
                    if (!aw_pend_nxt && !w_pend_nxt) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_q  <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= IDLE;
                        if (m_axi.bresp != AXI_RESP_OKAY) begin
                            mem_error <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi.rvalid) begin
                        rready_q     <= 1'b0;
                        mem_rd_data  <= m_axi.rdata;
                        mem_rd_valid <= 1'b1;
                        state        <= RD_CPL;
                        if (m_axi.rresp != AXI_RESP_OKAY) begin
                            mem_error <= 1'b1;
                        end
                    end
                end
                RD_CPL: begin
                    if (mem_rd_ready) begin
                        mem_rd_valid <= 1'b0;
                        mem_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_ready    <= 1'b1;
                    mem_rd_valid <= 1'b0;
                    awvalid_q    <= 1'b0;
                    wvalid_q     <= 1'b0;
                    bready_q     <= 1'b0;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                end
            endcase
        end
    end

    // Single-beat, full-width, fixed-ID bursts only
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awid    = RAM_ID_WIDTH'(AXI_ID);
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = axi_size(RAM_STRB_WIDTH);
    assign m_axi.awburst = AXI_BURST_INCR;

    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;

    assign m_axi.bready  = bready_q;

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arid    = RAM_ID_WIDTH'(AXI_ID);
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = axi_size(RAM_STRB_WIDTH);
    assign m_axi.arburst = AXI_BURST_INCR;

    assign m_axi.rready  = rready_q;

    // IDs and rlast carry no information with one single-beat transfer in flight
    assign unused_ok = ^{m_axi.bid, m_axi.rid, m_axi.rlast};

endmodule

// File: tb/tb_memory_driver.sv
// Directed bench for memory_driver: reactive AXI slave, transaction-level model, per-cycle compare.
// Model tracks which channel handshakes are owed, not the FSM encoding.
// Hand-computed literals pin addresses, data, latencies and error behaviour.
module tb_memory_driver;

    logic        aclk;
    logic        aresetn;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_data;
    logic        mem_error;

    memory_driver_if #(.ADDR_W(16), .DATA_W(32), .ID_W(8)) axi_if ();

    memory_driver dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_ready (mem_rd_ready),
        .mem_rd_data  (mem_rd_data),
        .mem_error    (mem_error),
        .m_axi        (axi_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // slave configuration
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // transaction-level model
    bit          m_busy, m_wr, m_rd, m_aw, m_w, m_ar, m_rdv, m_err;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          n_aw = 0, n_w = 0, n_ar = 0;
    logic [15:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [7:0]  last_arlen;
    logic        last_wlast;
    int          rd_acc_cyc, wr_acc_cyc, rd_lat = -1, wr_lat = -1, rdv_cycles = 0;
    bit          rd_arm, wr_arm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    // reactive AXI slave with configurable per-channel wait states
    initial begin
        int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        axi_if.awready = 0; axi_if.wready = 0; axi_if.arready = 0;
        axi_if.bvalid = 0; axi_if.bid = 8'h0; axi_if.bresp = 2'b00;
        axi_if.rvalid = 0; axi_if.rdata = 32'h0; axi_if.rid = 8'h0;
        axi_if.rresp = 2'b00; axi_if.rlast = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (axi_if.awvalid) begin axi_if.awready = (aw_wait >= cfg_aw_dly); aw_wait++; end
            else begin axi_if.awready = 0; aw_wait = 0; end
            if (axi_if.wvalid) begin axi_if.wready = (w_wait >= cfg_w_dly); w_wait++; end
            else begin axi_if.wready = 0; w_wait = 0; end
            if (axi_if.arvalid) begin axi_if.arready = (ar_wait >= cfg_ar_dly); ar_wait++; end
            else begin axi_if.arready = 0; ar_wait = 0; end
            if (axi_if.bready) begin
                axi_if.bvalid = (b_wait >= cfg_b_dly); axi_if.bresp = cfg_bresp; b_wait++;
            end else begin axi_if.bvalid = 0; b_wait = 0; end
            if (axi_if.rready) begin
                axi_if.rvalid = (r_wait >= cfg_r_dly); axi_if.rdata = cfg_rdata;
                axi_if.rresp = cfg_rresp; r_wait++;
            end else begin axi_if.rvalid = 0; r_wait = 0; end
        end
    end

    // compare process: check outputs against model, then advance model for the coming edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_mem_ready", mem_ready, 1);
            chk("rst_mem_rd_valid", mem_rd_valid, 0);
            chk("rst_mem_error", mem_error, 0);
            chk("rst_awvalid", axi_if.awvalid, 0);
            chk("rst_wvalid", axi_if.wvalid, 0);
            chk("rst_bready", axi_if.bready, 0);
            chk("rst_arvalid", axi_if.arvalid, 0);
            chk("rst_rready", axi_if.rready, 0);
            {m_busy, m_wr, m_rd, m_aw, m_w, m_ar, m_rdv, m_err} = '0;
            rd_arm = 0; wr_arm = 0;
        end else begin
            chk("mem_ready", mem_ready, !m_busy);
            chk("mem_error", mem_error, m_err);
            chk("mem_rd_valid", mem_rd_valid, m_rdv);
            if (m_rdv) chk("mem_rd_data", mem_rd_data, m_rdata);
            chk("awvalid", axi_if.awvalid, m_aw);
            chk("wvalid", axi_if.wvalid, m_w);
            chk("arvalid", axi_if.arvalid, m_ar);
            chk("bready", axi_if.bready, m_wr && !m_aw && !m_w);
            chk("rready", axi_if.rready, m_rd && !m_ar && !m_rdv);
            if (axi_if.awvalid) begin
                chk("awaddr", axi_if.awaddr, m_addr);
                chk("aw_len_size_burst_id", {axi_if.awlen, axi_if.awsize, axi_if.awburst, axi_if.awid},
                    {8'd0, 3'd2, 2'b01, 8'd0});
            end
            if (axi_if.wvalid) begin
                chk("wdata", axi_if.wdata, m_wdata);
                chk("wstrb_wlast", {axi_if.wstrb, axi_if.wlast}, {4'hF, 1'b1});
            end
            if (axi_if.arvalid) begin
                chk("araddr", axi_if.araddr, m_addr);
                chk("ar_len_size_burst_id", {axi_if.arlen, axi_if.arsize, axi_if.arburst, axi_if.arid},
                    {8'd0, 3'd2, 2'b01, 8'd0});
            end
            if (mem_rd_valid) rdv_cycles++;
            if (rd_arm && mem_rd_valid) begin rd_lat = cyc - rd_acc_cyc; rd_arm = 0; end
            if (wr_arm && mem_ready) begin wr_lat = cyc - wr_acc_cyc; wr_arm = 0; end

            if (mem_valid && mem_ready) begin
                if (mem_wr) begin
                    m_busy = 1; m_wr = 1; m_aw = 1; m_w = 1;
                    m_addr = mem_addr; m_wdata = mem_wr_data;
                    wr_acc_cyc = cyc; wr_arm = 1;
                    if (mem_rd) m_err = 1;
                end else if (mem_rd) begin
                    m_busy = 1; m_rd = 1; m_ar = 1; m_addr = mem_addr;
                    rd_acc_cyc = cyc; rd_arm = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (axi_if.awvalid && axi_if.awready) begin
                m_aw = 0; n_aw++; last_awaddr = axi_if.awaddr;
            end
            if (axi_if.wvalid && axi_if.wready) begin
                m_w = 0; n_w++; last_wdata = axi_if.wdata; last_wlast = axi_if.wlast;
            end
            if (axi_if.bvalid && axi_if.bready) begin
                m_busy = 0; m_wr = 0;
                if (axi_if.bresp != 2'b00) m_err = 1;
            end
            if (axi_if.arvalid && axi_if.arready) begin
                m_ar = 0; n_ar++; last_araddr = axi_if.araddr; last_arlen = axi_if.arlen;
            end
            if (axi_if.rvalid && axi_if.rready) begin
                m_rdv = 1; m_rdata = axi_if.rdata;
                if (axi_if.rresp != 2'b00) m_err = 1;
            end
            if (mem_rd_valid && mem_rd_ready) begin
                m_rdv = 0; m_rd = 0; m_busy = 0;
            end
        end
    end

    // present a request and hold it until the driver takes it
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
        bit ok = 0;
        mem_valid = 1; mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wr_data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (mem_ready) ok = 1;
        end
        @(posedge aclk); #1;
        mem_valid = 0; mem_rd = 0; mem_wr = 0;
        if (!ok) timeout("issue_accept");
    endtask

    task automatic wait_rd(input int hold, output logic [31:0] data);
        bit ok = 0;
        data = 32'h0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge aclk);
            if (mem_rd_valid) ok = 1;
        end
        if (!ok) begin
            timeout("wait_rd_valid");
            mem_rd_ready = 0;
            return;
        end
        data = mem_rd_data;
        if (hold > 0) begin
            repeat (hold) @(posedge aclk);
            #1 mem_rd_ready = 1;
        end
        @(posedge aclk); #1;
        mem_rd_ready = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge aclk);
            if (mem_ready) ok = 1;
        end
        @(posedge aclk); #1;
        if (!ok) timeout("wait_idle");
    endtask

    task automatic do_read(input logic [15:0] a, input int hold, output logic [31:0] data);
        mem_rd_ready = (hold == 0);
        issue(1, 0, a, 32'h0);
        wait_rd(hold, data);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        issue(0, 1, a, d);
        wait_idle();
    endtask

    initial begin
        logic [31:0] rd;
        int          n_ar0, n_aw0, n_w0;
        bit          ok;
        mem_valid = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wr_data = 0; mem_rd_ready = 0;
        aresetn = 1;
        #2 aresetn = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        @(posedge aclk); #1;

        // read 0x0040, zero-wait slave
        cfg_rdata = 32'hDEADBEEF;
        n_ar0 = n_ar;
        do_read(16'h0040, 0, rd);
        chk("t1_ar_count", n_ar - n_ar0, 1);
        chk("t1_araddr", last_araddr, 16'h0040);
        chk("t1_arlen", last_arlen, 8'd0);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_latency", rd_lat, 3);
        chk("t1_error", mem_error, 0);

        // write 0x0010, W accepted two cycles before AW
        cfg_w_dly = 0; cfg_aw_dly = 2;
        n_aw0 = n_aw; n_w0 = n_w;
        do_write(16'h0010, 32'h12345678);
        chk("t2_aw_count", n_aw - n_aw0, 1);
        chk("t2_w_count", n_w - n_w0, 1);
        chk("t2_awaddr", last_awaddr, 16'h0010);
        chk("t2_wdata", last_wdata, 32'h12345678);
        chk("t2_wlast", last_wlast, 1);
        chk("t2_error", mem_error, 0);
        chk("t2_ready", mem_ready, 1);

        // zero-wait write latency
        cfg_aw_dly = 0;
        do_write(16'h0020, 32'hA5A5A5A5);
        chk("t3_wr_latency", wr_lat, 3);

        // completion stalled five cycles by the engine
        cfg_rdata = 32'hCAFEF00D; cfg_ar_dly = 1; cfg_r_dly = 1;
        rdv_cycles = 0;
        do_read(16'h0080, 5, rd);
        chk("t4_rdv_cycles", rdv_cycles, 6);
        chk("t4_rd_data", rd, 32'hCAFEF00D);
        cfg_ar_dly = 0; cfg_r_dly = 0;

        // SLVERR write response, then a clean read: error is sticky
        cfg_bresp = 2'b10;
        do_write(16'h0030, 32'h00000001);
        chk("t5_error_after_slverr", mem_error, 1);
        cfg_bresp = 2'b00;
        cfg_rdata = 32'h11112222;
        do_read(16'h0044, 0, rd);
        chk("t5_error_sticky", mem_error, 1);
        chk("t5_rd_data", rd, 32'h11112222);

        // read and write together: write wins
        n_ar0 = n_ar; n_aw0 = n_aw;
        issue(1, 1, 16'h0050, 32'h55AA55AA);
        wait_idle();
        chk("t6_no_ar", n_ar - n_ar0, 0);
        chk("t6_aw_count", n_aw - n_aw0, 1);
        chk("t6_awaddr", last_awaddr, 16'h0050);
        chk("t6_wdata", last_wdata, 32'h55AA55AA);
        chk("t6_error", mem_error, 1);

        // reset while waiting for read data
        cfg_r_dly = 8;
        n_ar0 = n_ar;
        mem_rd_ready = 1;
        issue(1, 0, 16'h0060, 32'h0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (axi_if.rready) ok = 1;
        end
        if (!ok) timeout("t7_reach_rd_resp");
        @(posedge aclk); #1 aresetn = 0;
        @(negedge aclk);
        chk("t7_arvalid", axi_if.arvalid, 0);
        chk("t7_rready", axi_if.rready, 0);
        chk("t7_rd_valid", mem_rd_valid, 0);
        chk("t7_ready", mem_ready, 1);
        chk("t7_error_cleared", mem_error, 0);
        @(posedge aclk); #1 aresetn = 1;
        mem_rd_ready = 0;
        cfg_r_dly = 0;
        repeat (6) @(posedge aclk); #1;
        chk("t7_no_replay", n_ar - n_ar0, 1);
        chk("t7_idle_after", mem_ready, 1);

        // fresh read after reset
        cfg_rdata = 32'h0BADCAFE;
        do_read(16'h0100, 0, rd);
        chk("t8_araddr", last_araddr, 16'h0100);
        chk("t8_rd_data", rd, 32'h0BADCAFE);
        chk("t8_error", mem_error, 0);

        // request with neither direction: dropped, flagged
        n_ar0 = n_ar; n_aw0 = n_aw;
        mem_valid = 1;
        @(posedge aclk); #1 mem_valid = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("t9_error", mem_error, 1);
        chk("t9_ready", mem_ready, 1);
        chk("t9_no_traffic", (n_ar - n_ar0) + (n_aw - n_aw0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
